pio_tctrl_mdev: RTL

Parametrised ATA PIO-mode timing controller. It supports NDEV per-device timing register sets, an IORDY input synchroniser, an IORDY wait timeout with an error flag, and a one-deep pending request slot so that back-to-back cycles run with no idle clock. It sits between the host-side PIO command logic and the ATA pin drivers. It generates DIOR-/DIOW- (active-high internally), the output enable, the data strobe and the completion strobe.

---
 rtl/pio_tctrl_mdev.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/pio_tctrl_mdev.sv
// ATA PIO timing controller: per-device timing sets, IORDY synchroniser with
// wait timeout, and a one-deep pending slot so back-to-back cycles need no idle clk.
module pio_tctrl_mdev #(
  parameter int unsigned TWIDTH  = 8,
  parameter int unsigned NDEV    = 2,
  parameter int unsigned DW      = 1,
  parameter int unsigned TOWIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic                   we,
  input  logic [DW-1:0]          dev,
  input  logic [NDEV*TWIDTH-1:0] T1,
  input  logic [NDEV*TWIDTH-1:0] T2,
  input  logic [NDEV*TWIDTH-1:0] T4,
  input  logic [NDEV*TWIDTH-1:0] Teoc,
  input  logic [NDEV-1:0]        IORDY_en,
  input  logic [TOWIDTH-1:0]     Tto,
  input  logic                   IORDY,
  output logic                   DIOR,
  output logic                   DIOW,
  output logic                   oe,
  output logic                   dstrb,
  output logic                   done,
  output logic                   busy,
  output logic                   err
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, WAITRDY, RECOV} state_e;

  // Fully resolved request: timing captured at acceptance, zero fields forced to 1.
  typedef struct packed {
    logic              we;
    logic              ien;
    logic [TWIDTH-1:0] t1;
    logic [TWIDTH-1:0] t2;
    logic [TWIDTH-1:0] t4;
    logic [TWIDTH-1:0] trec;
  } req_t;

  function automatic logic [TWIDTH-1:0] nz(input logic [TWIDTH-1:0] v);
    return (v == '0) ? TWIDTH'(1) : v;
  endfunction

  state_e             state_q, state_d;
  logic [TWIDTH-1:0]  cnt_q, cnt_d;
  logic [TWIDTH-1:0]  t4_q, t4_d;
  logic [TOWIDTH-1:0] to_q, to_d;
  req_t               cur_q, cur_d;
  req_t               slot_q, slot_d;
  logic               slot_vld_q, slot_vld_d;
  logic               err_q, err_d;
  logic [1:0]         sync_q;

  logic dior_q, diow_q, oe_q, dstrb_q, done_q, busy_q;
  logic dior_d, diow_d, oe_d, dstrb_d, done_d, busy_d, strobe_d;

  logic [DW-1:0]     sel_c;
  logic [NDEV-1:0]   ien_vec_c;
  logic [TWIDTH-1:0] t4_c, teoc_c;
  req_t              req_c;
  logic              rdy_c;

  // Decode the incoming request against its (range-checked) timing set.
  always_comb begin
    sel_c      = (32'(dev) < NDEV) ? dev : '0;
    ien_vec_c  = IORDY_en >> sel_c;
    t4_c       = nz(TWIDTH'(T4 >> (32'(sel_c) * TWIDTH)));
    teoc_c     = nz(TWIDTH'(Teoc >> (32'(sel_c) * TWIDTH)));
    req_c.we   = we;
    req_c.ien  = ien_vec_c[0];
    req_c.t1   = nz(TWIDTH'(T1 >> (32'(sel_c) * TWIDTH)));
    req_c.t2   = nz(TWIDTH'(T2 >> (32'(sel_c) * TWIDTH)));
    req_c.t4   = t4_c;
    req_c.trec = (t4_c > teoc_c) ? t4_c : teoc_c;
  end

  assign rdy_c = !cur_q.ien || sync_q[1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    t4_d       = (t4_q != '0) ? t4_q - TWIDTH'(1) : '0;
    cur_d      = cur_q;
    slot_d     = slot_q;
    slot_vld_d = slot_vld_q;
    err_d      = err_q;

    if (go && (state_q != IDLE) && !slot_vld_q) begin
      slot_vld_d = 1'b1;
      slot_d     = req_c;
    end

    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_d = SETUP;
          cur_d   = req_c;
          cnt_d   = req_c.t1;
          err_d   = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q <= TWIDTH'(1)) begin
          state_d = PULSE;
          cnt_d   = cur_q.t2;
        end else begin
          cnt_d = cnt_q - TWIDTH'(1);
        end
      end
      PULSE: begin
        if (cnt_q <= TWIDTH'(1)) begin
          if (rdy_c) begin
            state_d = RECOV;
            cnt_d   = cur_q.trec;
            t4_d    = cur_q.t4;
          end else begin
            state_d = WAITRDY;
            to_d    = Tto;
          end
        end else begin
          cnt_d = cnt_q - TWIDTH'(1);
        end
      end
      WAITRDY: begin
        // Ready wins over a timeout expiring in the same clk; to_q == 0 means no timeout.
        if (rdy_c) begin
          state_d = RECOV;
          cnt_d   = cur_q.trec;
          t4_d    = cur_q.t4;
        end else if (to_q == TOWIDTH'(1)) begin
          state_d = RECOV;
          cnt_d   = cur_q.trec;
          t4_d    = cur_q.t4;
          err_d   = 1'b1;
        end else if (to_q != '0) begin
          to_d = to_q - TOWIDTH'(1);
        end
      end
      RECOV: begin
        if (cnt_q <= TWIDTH'(1)) begin
          if (slot_vld_q) begin
            state_d    = SETUP;
            cur_d      = slot_q;
            cnt_d      = slot_q.t1;
            slot_vld_d = 1'b0;
            err_d      = 1'b0;
          end else if (go) begin
            state_d    = SETUP;
            cur_d      = req_c;
            cnt_d      = req_c.t1;
            slot_vld_d = 1'b0;
            err_d      = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - TWIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    strobe_d = (state_d == PULSE) || (state_d == WAITRDY);
    dior_d   = strobe_d && !cur_d.we;
    diow_d   = strobe_d && cur_d.we;
    oe_d     = cur_d.we && ((state_d == SETUP) || strobe_d ||
                            ((state_d == RECOV) && (t4_d != '0)));
    dstrb_d  = (state_d == RECOV) && (state_q != RECOV);
    done_d   = (state_d == RECOV) && (t4_d == TWIDTH'(1));
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      t4_q       <= '0;
      to_q       <= '0;
      cur_q      <= '0;
      slot_q     <= '0;
      slot_vld_q <= 1'b0;
      err_q      <= 1'b0;
      sync_q     <= '0;
      dior_q     <= 1'b0;
      diow_q     <= 1'b0;
      oe_q       <= 1'b0;
      dstrb_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      t4_q       <= t4_d;
      to_q       <= to_d;
      cur_q      <= cur_d;
      slot_q     <= slot_d;
      slot_vld_q <= slot_vld_d;
      err_q      <= err_d;
      sync_q     <= {sync_q[0], IORDY};
      dior_q     <= dior_d;
      diow_q     <= diow_d;
      oe_q       <= oe_d;
      dstrb_q    <= dstrb_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign DIOR  = dior_q;
  assign DIOW  = diow_q;
  assign oe    = oe_q;
  assign dstrb = dstrb_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule
